uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares one UART transmitter core between NUM_REQ byte-stream requesters. It grants one requester at a time and hands bytes to the TX core with a one-cycle start pulse, then tracks the core's busy flag. It releases the grant at the end of a packet, on burst-limit expiry, or on requester drop. It sits between the client logic and the TX core, which is clocked by the baud-rate generator enables.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
MAX_BURST, 4, max bytes per grant before forced re-arbitration (1..255)
BUSY_TO, 4, clk cycles allowed for tx_busy to rise after tx_start (1..15)

Ports:
clk  input  1  system clock
areset  input  1  reset, synchronous, active-high
req  input  NUM_REQ  per-requester byte available; hold with data until ack
req_data  input  8*NUM_REQ  byte i at [8*i+7:8*i]
req_last  input  NUM_REQ  current byte is last of packet
ack  output  NUM_REQ  one-cycle pulse: byte accepted
grant  output  NUM_REQ  one-hot current owner; 0 when idle
cur_id  output  $clog2(NUM_REQ)  index of owner (valid while grant!=0)
tx_data  output  8  byte to TX core
tx_start  output  1  one-cycle start pulse to TX core
tx_busy  input  1  TX core frame in progress
err  output  1  sticky: tx_busy failed to rise within BUSY_TO

Behaviour:
- Everything is sampled on posedge clk. areset has priority over all other inputs.
- Reset values:
  - Outputs: grant=0, ack=0, tx_start=0, tx_data=0, cur_id=0, err=0.
  - Internal: last_id=NUM_REQ-1, so requester 0 wins first; burst_cnt=0; state=IDLE.
- Reset mid-frame abandons the byte. Nothing is restored.
- State machine IDLE, ISSUE, WAIT_BUSY, WAIT_DONE:
  - IDLE, req!=0 and tx_busy=0:
    - Pick the first set req scanning from last_id+1 with wrap modulo NUM_REQ.
    - Register grant/cur_id; clear burst_cnt; go ISSUE.
    - If tx_busy=1, stay in IDLE.
  - ISSUE, req[cur_id]=1:
    - tx_data<=byte; tx_start<=1; ack[cur_id]<=1, each for exactly one cycle.
    - Latch req_last[cur_id] as last_f; burst_cnt+1; go WAIT_BUSY.
  - ISSUE, req[cur_id]=0: no start and no ack; release.
  - WAIT_BUSY:
    - tx_busy=1 -> WAIT_DONE.
    - After BUSY_TO cycles without tx_busy: set err; release.
  - WAIT_DONE, tx_busy falls to 0:
    - Release if last_f=1, or burst_cnt==MAX_BURST, or req[cur_id]=0.
    - Otherwise go ISSUE; same owner, no re-arbitration.
- Release: grant<=0; last_id<=cur_id; state IDLE. The next arbitration is no earlier than the following cycle.
- Latency:
  - req rises at edge t (IDLE, core idle): grant at t+1, tx_start/ack at t+2.
  - Back-to-back bytes: tx_start 1 cycle after the tx_busy falling edge is sampled.
- Single outstanding byte: tx_start is never asserted while tx_busy=1 or in WAIT states.
- Simultaneous: the winner is set by the rotation only; other requesters are untouched. Their ack stays 0.
- A requester may change req_data only after its ack.
- burst_cnt is 8-bit and never wraps (release at MAX_BURST).
- err is cleared only by areset.

Optional Feature:
UART_ARB_PRIO_EN
- Defined:
  - Requester 0 has strict priority in IDLE arbitration.
  - In WAIT_DONE, if req[0]=1 and cur_id!=0, release at the byte boundary, i.e. preempt, even mid-packet.
  - last_id is not updated when the winner is 0, so the rotation among 1..NUM_REQ-1 is preserved.
- Undefined: pure round-robin as above; no preemption.

Test Plan:
- Reset, then req=4'b0001 with byte 0x55 and last=1 (core model asserts busy 1 cycle after start and holds it 10 cycles) -> grant=0001 at t+1; tx_start, ack[0] and tx_data=0x55 at t+2; grant=0 after busy falls.
- req=4'b1111 held, each last=1 -> grant order 0,1,2,3,0; exactly one tx_start per grant.
- req[2] streams 6 bytes with last=0, MAX_BURST=4, req[1] also set -> 4 starts for id 2, then grant to id 3? no: the scan from 3 wraps to 1; id 1 is served next, then id 2 resumes.
- Core model never raises busy, BUSY_TO=4 -> err=1 five cycles after tx_start; grant=0; next request still served and err stays 1.
- req[1] drops during WAIT_DONE -> release when busy falls; no further tx_start for id 1.
- Assert areset in WAIT_DONE -> next cycle all outputs 0; a new req=0001 is served with normal t+2 latency.
- With UART_ARB_PRIO_EN: id 3 mid-packet and req[0] rises -> after the current byte, grant=0001; id 3 regains the grant afterwards.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the byte-stream clients, the TX arbiter and the UART TX core.
// The slave modport is the arbiter's view; master is everything around it (clients plus core).
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
) ();
    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   ack;
    logic [NUM_REQ-1:0]   grant;
    logic [IDW-1:0]       cur_id;
    logic [7:0]           tx_data;
    logic                 tx_start;
    logic                 tx_busy;
    logic                 err;

    modport slave (
        input  req, req_data, req_last, tx_busy,
        output ack, grant, cur_id, tx_data, tx_start, err
    );

    modport master (
        output req, req_data, req_last, tx_busy,
        input  ack, grant, cur_id, tx_data, tx_start, err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX core between NUM_REQ byte-stream requesters.
// Optional UART_ARB_PRIO_EN: requester 0 gets strict priority and preempts at byte boundaries.
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 4,
    parameter int BUSY_TO   = 4
) (
    input  logic             clk,
    input  logic             areset,
    uart_tx_arbiter_if.slave bus
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam logic [IDW-1:0]     LAST_ID_RST = IDW'(NUM_REQ - 1);
    localparam logic [7:0]         MAX_BURST_L = 8'(MAX_BURST);
    localparam logic [3:0]         BUSY_TO_L   = 4'(BUSY_TO);
    localparam logic [NUM_REQ-1:0] ONE_HOT0    = NUM_REQ'(1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDW-1:0]     cur_id_q, cur_id_d;
    logic [IDW-1:0]     last_id_q, last_id_d;
    logic [7:0]         burst_q, burst_d;
    logic [3:0]         timer_q, timer_d;
    logic               last_f_q, last_f_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               tx_start_q, tx_start_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               err_q, err_d;

    logic               rel;
    logic               preempt;
    logic               pick_ok;
    logic [IDW-1:0]     pick_id;
    int unsigned        scan_idx;

    logic               cur_req;
    logic               cur_last;
    logic [7:0]         cur_byte;

    assign cur_req  = bus.req[cur_id_q];
    assign cur_last = bus.req_last[cur_id_q];
    assign cur_byte = bus.req_data[{cur_id_q, 3'b000} +: 8];

`ifdef UART_ARB_PRIO_EN
    assign preempt = bus.req[0] && (cur_id_q != '0);
`else
    assign preempt = 1'b0;
`endif

    // Rotating scan starting just after the previous owner; first hit wins.
    always_comb begin
        pick_ok  = 1'b0;
        pick_id  = '0;
        scan_idx = 0;
        for (int unsigned k = 0; k < unsigned'(NUM_REQ); k++) begin
            scan_idx = (32'(last_id_q) + 1 + k) % unsigned'(NUM_REQ);
            if (!pick_ok && bus.req[scan_idx[IDW-1:0]]) begin
                pick_ok = 1'b1;
                pick_id = scan_idx[IDW-1:0];
            end
        end
`ifdef UART_ARB_PRIO_EN
        if (bus.req[0]) begin
            pick_ok = 1'b1;
            pick_id = '0;
        end
`endif
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        cur_id_d   = cur_id_q;
        last_id_d  = last_id_q;
        burst_d    = burst_q;
        timer_d    = timer_q;
        last_f_d   = last_f_q;
        tx_data_d  = tx_data_q;
        err_d      = err_q;
        ack_d      = '0;
        tx_start_d = 1'b0;
        rel        = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_ok && !bus.tx_busy) begin
                    grant_d  = ONE_HOT0 << pick_id;
                    cur_id_d = pick_id;
                    burst_d  = '0;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (!cur_req) begin
                    rel = 1'b1;
                end else if (!bus.tx_busy) begin
                    tx_data_d  = cur_byte;
                    tx_start_d = 1'b1;
                    ack_d      = ONE_HOT0 << cur_id_q;
                    last_f_d   = cur_last;
                    burst_d    = burst_q + 8'd1;
                    timer_d    = '0;
                    state_d    = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (timer_q == BUSY_TO_L) begin
                    err_d = 1'b1;
                    rel   = 1'b1;
                end else begin
                    timer_d = timer_q + 4'd1;
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    if (last_f_q || (burst_q == MAX_BURST_L) || !cur_req || preempt) begin
                        rel = 1'b1;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (rel) begin
            grant_d = '0;
            state_d = IDLE;
`ifdef UART_ARB_PRIO_EN
            // Requester 0 is served outside the rotation, so it never moves the pointer.
            if (cur_id_q != '0) begin
                last_id_d = cur_id_q;
            end
`else
            last_id_d = cur_id_q;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            cur_id_q   <= '0;
            last_id_q  <= LAST_ID_RST;
            burst_q    <= '0;
            timer_q    <= '0;
            last_f_q   <= 1'b0;
            ack_q      <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            cur_id_q   <= cur_id_d;
            last_id_q  <= last_id_d;
            burst_q    <= burst_d;
            timer_q    <= timer_d;
            last_f_q   <= last_f_d;
            ack_q      <= ack_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            err_q      <= err_d;
        end
    end

    assign bus.grant    = grant_q;
    assign bus.cur_id   = cur_id_q;
    assign bus.ack      = ack_q;
    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.err      = err_q;

    a_grant_onehot0: assert property (@(posedge clk) disable iff (areset) $onehot0(grant_q));
    a_ack_matches:   assert property (@(posedge clk) disable iff (areset)
                                      ack_q == (tx_start_q ? grant_q : '0));
    a_err_sticky:    assert property (@(posedge clk) disable iff (areset) err_q |=> err_q);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester byte sources, a TX core model and a start monitor.
module tb_uart_tx_arbiter;
    localparam int NUM_REQ   = 4;
    localparam int MAX_BURST = 4;
    localparam int BUSY_TO   = 4;
    localparam int BUSY_HOLD = 10;

    typedef struct {
        int         id;
        logic [7:0] data;
    } exp_t;

    logic clk     = 1'b0;
    logic areset  = 1'b1;
    logic core_en = 1'b1;
    int   busy_cnt = 0;

    int vectors     = 0;
    int miscompares = 0;
    int n_starts    = 0;
    int n_grants    = 0;
    logic [NUM_REQ-1:0] prev_grant = '0;

    exp_t       sb[$];
    logic [7:0] src_data [NUM_REQ][16];
    logic       src_last [NUM_REQ][16];
    int         src_len  [NUM_REQ];
    int         src_pos  [NUM_REQ];

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .MAX_BURST(MAX_BURST),
        .BUSY_TO  (BUSY_TO)
    ) dut (
        .clk   (clk),
        .areset(areset),
        .bus   (bus)
    );

    // TX core model: busy rises one cycle after a start and stays high BUSY_HOLD cycles.
    always @(posedge clk) begin
        if (areset) begin
            bus.tx_busy <= 1'b0;
            busy_cnt    <= 0;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) bus.tx_busy <= 1'b0;
        end else if (bus.tx_start && core_en) begin
            bus.tx_busy <= 1'b1;
            busy_cnt    <= BUSY_HOLD;
        end
    end

    task automatic apply_src();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (src_pos[i] < src_len[i]) begin
                bus.req[i]            = 1'b1;
                bus.req_data[8*i +: 8] = src_data[i][src_pos[i]];
                bus.req_last[i]       = src_last[i][src_pos[i]];
            end else begin
                bus.req[i]      = 1'b0;
                bus.req_last[i] = 1'b0;
            end
        end
    endtask

    task automatic clear_src();
        for (int i = 0; i < NUM_REQ; i++) begin
            src_len[i] = 0;
            src_pos[i] = 0;
        end
        bus.req_data = '0;
        apply_src();
    endtask

    task automatic add_byte(input int i, input logic [7:0] d, input logic l);
        src_data[i][src_len[i]] = d;
        src_last[i][src_len[i]] = l;
        src_len[i]++;
    endtask

    task automatic push_exp(input int i, input logic [7:0] d);
        sb.push_back('{id: i, data: d});
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++)
            if (bus.ack[i] === 1'b1) src_pos[i]++;
        apply_src();
    endtask

    task automatic do_reset();
        areset  = 1'b1;
        core_en = 1'b1;
        sb.delete();
        clear_src();
        tick();
        tick();
        areset = 1'b0;
    endtask

    // what: 0 = grant!=0, 1 = tx_start, 2 = tx_busy
    task automatic wait_for(input int what, input int bound, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < bound; c++) begin
            tick();
            if ((what == 0 && bus.grant != '0) || (what == 1 && bus.tx_start === 1'b1) ||
                (what == 2 && bus.tx_busy === 1'b1)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int bound, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < bound; c++) begin
            tick();
            if (sb.size() == 0 && bus.grant == '0 && bus.tx_busy == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({bus.grant, bus.ack, bus.tx_start} !== '0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got grant=%b ack=%b start=%b, want all 0", bus.grant, bus.ack, bus.tx_start);
        end
        vectors++;
        if ({bus.tx_data, bus.cur_id} !== '0) begin
            miscompares++;
            $display("FAIL reset_data: got tx_data=%h cur_id=%0d, want 0", bus.tx_data, bus.cur_id);
        end
        vectors++;
        if (bus.err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_err: got %b, want 0", bus.err);
        end
    endtask

    task automatic test_single();
        bit ok;
        do_reset();
        add_byte(0, 8'h55, 1'b1);
        push_exp(0, 8'h55);
        apply_src();
        tick();
        vectors++;
        if (bus.grant !== 4'b0001 || bus.tx_start !== 1'b0) begin
            miscompares++;
            $display("FAIL single_grant: got grant=%b start=%b, want 0001/0", bus.grant, bus.tx_start);
        end
        tick();
        vectors++;
        if (bus.tx_start !== 1'b1 || bus.ack !== 4'b0001 || bus.tx_data !== 8'h55) begin
            miscompares++;
            $display("FAIL single_start: got start=%b ack=%b data=%h, want 1/0001/55", bus.tx_start, bus.ack, bus.tx_data);
        end
        wait_idle(60, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL single_release: got grant=%b busy=%b, want grant 0 after busy falls", bus.grant, bus.tx_busy);
        end
        vectors++;
        if (bus.err !== 1'b0) begin
            miscompares++;
            $display("FAIL single_err: got %b, want 0", bus.err);
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        int s0, g0;
        do_reset();
        add_byte(0, 8'hA0, 1'b1);
        add_byte(0, 8'hA4, 1'b1);
        add_byte(1, 8'hA1, 1'b1);
        add_byte(2, 8'hA2, 1'b1);
        add_byte(3, 8'hA3, 1'b1);
`ifdef UART_ARB_PRIO_EN
        push_exp(0, 8'hA0); push_exp(0, 8'hA4);
        push_exp(1, 8'hA1); push_exp(2, 8'hA2); push_exp(3, 8'hA3);
`else
        push_exp(0, 8'hA0); push_exp(1, 8'hA1); push_exp(2, 8'hA2);
        push_exp(3, 8'hA3); push_exp(0, 8'hA4);
`endif
        s0 = n_starts;
        g0 = n_grants;
        apply_src();
        wait_idle(400, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL rr_done: got %0d bytes pending, want 0", sb.size());
        end
        vectors++;
        if (n_starts - s0 != 5 || n_grants - g0 != 5) begin
            miscompares++;
            $display("FAIL rr_counts: got starts=%0d grants=%0d, want 5/5", n_starts - s0, n_grants - g0);
        end
    endtask

    task automatic test_burst();
        bit ok;
        int s0;
        do_reset();
        for (int b = 0; b < 6; b++) add_byte(2, 8'hB0 + 8'(b), (b == 5));
        for (int b = 0; b < 4; b++) push_exp(2, 8'hB0 + 8'(b));
        s0 = n_starts;
        apply_src();
        wait_for(0, 10, ok);
        vectors++;
        if (!ok || bus.cur_id !== 2'd2) begin
            miscompares++;
            $display("FAIL burst_first: got cur_id=%0d ok=%0d, want 2", bus.cur_id, ok);
        end
        add_byte(1, 8'hC1, 1'b1);
        push_exp(1, 8'hC1);
        push_exp(2, 8'hB4);
        push_exp(2, 8'hB5);
        apply_src();
        wait_idle(500, ok);
        vectors++;
        if (!ok || n_starts - s0 != 7) begin
            miscompares++;
            $display("FAIL burst_done: got starts=%0d pending=%0d, want 7/0", n_starts - s0, sb.size());
        end
    endtask

    task automatic test_timeout();
        bit ok;
        do_reset();
        core_en = 1'b0;
        add_byte(0, 8'h66, 1'b1);
        push_exp(0, 8'h66);
        apply_src();
        wait_for(1, 10, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL to_start: got no tx_start, want one");
        end
        repeat (4) tick();
        vectors++;
        if (bus.err !== 1'b0) begin
            miscompares++;
            $display("FAIL to_early: got err=%b 4 cycles after start, want 0", bus.err);
        end
        tick();
        vectors++;
        if (bus.err !== 1'b1 || bus.grant !== '0) begin
            miscompares++;
            $display("FAIL to_err: got err=%b grant=%b 5 cycles after start, want 1/0000", bus.err, bus.grant);
        end
        core_en = 1'b1;
        add_byte(1, 8'h77, 1'b1);
        push_exp(1, 8'h77);
        apply_src();
        wait_idle(80, ok);
        vectors++;
        if (!ok || bus.err !== 1'b1) begin
            miscompares++;
            $display("FAIL to_next: got ok=%0d err=%b, want served with err 1", ok, bus.err);
        end
    endtask

    task automatic test_drop();
        bit ok;
        int s0;
        do_reset();
        add_byte(1, 8'hD0, 1'b0);
        add_byte(1, 8'hD1, 1'b0);
        add_byte(1, 8'hD2, 1'b0);
        push_exp(1, 8'hD0);
        apply_src();
        wait_for(2, 20, ok);
        tick();
        src_len[1] = src_pos[1];
        apply_src();
        s0 = n_starts;
        wait_idle(60, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL drop_release: got grant=%b, want 0000", bus.grant);
        end
        repeat (20) tick();
        vectors++;
        if (n_starts != s0 || bus.grant !== '0) begin
            miscompares++;
            $display("FAIL drop_quiet: got %0d extra starts grant=%b, want 0/0000", n_starts - s0, bus.grant);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset();
        add_byte(0, 8'hE0, 1'b0);
        add_byte(0, 8'hE1, 1'b0);
        push_exp(0, 8'hE0);
        apply_src();
        wait_for(2, 20, ok);
        tick();
        areset = 1'b1;
        clear_src();
        tick();
        vectors++;
        if ({bus.grant, bus.ack, bus.tx_start, bus.tx_data, bus.cur_id, bus.err} !== '0) begin
            miscompares++;
            $display("FAIL rstmid_outputs: got grant=%b ack=%b start=%b data=%h id=%0d err=%b, want 0",
                     bus.grant, bus.ack, bus.tx_start, bus.tx_data, bus.cur_id, bus.err);
        end
        areset = 1'b0;
        add_byte(0, 8'h5A, 1'b1);
        push_exp(0, 8'h5A);
        apply_src();
        tick();
        vectors++;
        if (bus.grant !== 4'b0001) begin
            miscompares++;
            $display("FAIL rstmid_grant: got %b, want 0001", bus.grant);
        end
        tick();
        vectors++;
        if (bus.tx_start !== 1'b1 || bus.tx_data !== 8'h5A) begin
            miscompares++;
            $display("FAIL rstmid_start: got start=%b data=%h, want 1/5a", bus.tx_start, bus.tx_data);
        end
        wait_idle(60, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL rstmid_done: got grant=%b, want 0000", bus.grant);
        end
    endtask

`ifdef UART_ARB_PRIO_EN
    task automatic test_prio();
        bit ok;
        do_reset();
        for (int b = 0; b < 4; b++) add_byte(3, 8'hF0 + 8'(b), (b == 3));
        push_exp(3, 8'hF0);
        apply_src();
        wait_for(2, 20, ok);
        tick();
        add_byte(0, 8'h01, 1'b1);
        push_exp(0, 8'h01);
        for (int b = 1; b < 4; b++) push_exp(3, 8'hF0 + 8'(b));
        apply_src();
        wait_for(1, 60, ok);
        vectors++;
        if (!ok || bus.cur_id !== 2'd0 || bus.grant !== 4'b0001) begin
            miscompares++;
            $display("FAIL prio_preempt: got id=%0d grant=%b, want 0/0001", bus.cur_id, bus.grant);
        end
        wait_idle(300, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL prio_resume: got %0d bytes pending, want 0", sb.size());
        end
    endtask
`endif

    initial begin
        bus.req      = '0;
        bus.req_data = '0;
        bus.req_last = '0;
        clear_src();

        fork
            begin : monitor
                exp_t e;
                logic [NUM_REQ-1:0] want_ack;
                forever begin
                    @(negedge clk);
                    if (!areset) begin
                        if (bus.grant != '0 && prev_grant == '0) n_grants++;
                        if (bus.tx_start === 1'b1) begin
                            n_starts++;
                            vectors++;
                            if (sb.size() == 0) begin
                                miscompares++;
                                $display("FAIL sb_unexpected: got start id=%0d data=%h, want none", bus.cur_id, bus.tx_data);
                            end else begin
                                e = sb.pop_front();
                                want_ack = NUM_REQ'(1) << e.id;
                                if (bus.tx_data !== e.data || int'(bus.cur_id) != e.id || bus.ack !== want_ack) begin
                                    miscompares++;
                                    $display("FAIL sb_byte: got id=%0d data=%h ack=%b, want id=%0d data=%h ack=%b",
                                             bus.cur_id, bus.tx_data, bus.ack, e.id, e.data, want_ack);
                                end
                            end
                        end else begin
                            vectors++;
                            if (bus.ack !== '0) begin
                                miscompares++;
                                $display("FAIL stray_ack: got ack=%b without start, want 0000", bus.ack);
                            end
                        end
                    end
                    prev_grant = bus.grant;
                end
            end
        join_none

        test_reset();
        test_single();
        test_round_robin();
        test_burst();
        test_timeout();
        test_drop();
        test_reset_mid();
`ifdef UART_ARB_PRIO_EN
        test_prio();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
